// File: rtl/irq_scheduler_pkg.sv
// Shared definitions for the interrupt scheduler: register word offsets and
// FSM state encodings.
package irq_scheduler_pkg;

    localparam logic [1:0] MASK_OFS = 2'd0;
    localparam logic [1:0] PEND_OFS = 2'd1;
    localparam logic [1:0] ISR_OFS  = 2'd2;
    localparam logic [1:0] STAT_OFS = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_t;

endpackage

// File: rtl/irq_scheduler_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module prio_enc #(
    parameter int N   = 6,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    output logic           valid,
    output logic [IDW-1:0] id
);

    // Scan from the top so the lowest set bit is the last one assigned.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = IDW'(i);
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// Memory-mapped interrupt scheduler: edge capture, masking, fixed priority,
// request/ack handshake and single in-service tracking closed by EOI.
module irq_scheduler
    import irq_scheduler_pkg::*;
#(
    parameter int NSRC = 6,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] src_irq,
    output logic            int_req,
    output logic [IDW-1:0]  int_id,
    input  logic            int_ack
);

    localparam int DW = (NSRC > IDW) ? NSRC : IDW;

    state_t          state, state_next;
    logic            req_next;
    logic [IDW-1:0]  id_next;
    logic            ack_fire, eoi_fire;
    logic [NSRC-1:0] mask, pending, inservice, prev_irq;
    logic [NSRC-1:0] pend_next, edges, id_onehot;
    logic            armed;
    logic            win_valid;
    logic [IDW-1:0]  win_id;
    logic            busy, eoi_write;
    logic            unused_bits;

    assign unused_bits = ^{Addr[31:4], Din[31:DW]};

    // The first edge after reset only samples src_irq, so a line held high
    // across reset release is not mistaken for a fresh rising edge.
    assign edges     = armed ? (src_irq & ~prev_irq) : '0;
    assign id_onehot = NSRC'(1) << int_id;
    assign busy      = (state == SERVICE);
    assign eoi_write = WE && (Addr[3:2] == STAT_OFS);

    prio_enc #(.N(NSRC), .IDW(IDW)) u_prio (
        .req   (pending & mask),
        .valid (win_valid),
        .id    (win_id)
    );

    always_comb begin
        state_next = state;
        req_next   = int_req;
        id_next    = int_id;
        ack_fire   = 1'b0;
        eoi_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                    id_next    = win_id;
                end
            end
            REQ: begin
                if (int_ack) begin
                    ack_fire   = 1'b1;
                    state_next = SERVICE;
                    req_next   = 1'b0;
                end
            end
            SERVICE: begin
                if (eoi_write && (Din[IDW-1:0] == int_id)) begin
                    eoi_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= '0;
        end else begin
            state   <= state_next;
            int_req <= req_next;
            int_id  <= id_next;
        end
    end

    // Clears are applied first so a coincident capture edge always wins.
    always_comb begin
        pend_next = pending;
        if (WE && (Addr[3:2] == PEND_OFS)) pend_next = pend_next & ~Din[NSRC-1:0];
        if (ack_fire) pend_next = pend_next & ~id_onehot;
        pend_next = pend_next | edges;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask      <= '0;
            pending   <= '0;
            inservice <= '0;
            prev_irq  <= '0;
            armed     <= 1'b0;
        end else begin
            prev_irq <= src_irq;
            armed    <= 1'b1;
            pending  <= pend_next;
            if (WE && (Addr[3:2] == MASK_OFS)) mask <= Din[NSRC-1:0];
            if (ack_fire) inservice <= id_onehot;
            else if (eoi_fire) inservice <= '0;
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            MASK_OFS: Dout = {{(32-NSRC){1'b0}}, mask};
            PEND_OFS: Dout = {{(32-NSRC){1'b0}}, pending};
            ISR_OFS:  Dout = {{(32-NSRC){1'b0}}, inservice};
            default:  Dout = {busy, {(31-IDW){1'b0}}, int_id};
        endcase
    end

endmodule

// File: tb/tb_irq_scheduler.sv
// Self-checking bench for irq_scheduler: directed stimulus, a behavioural
// model compared every cycle, and hand-computed literal expectations.
module tb_irq_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic [5:0]  src_irq = '0;
    logic        int_req;
    logic [2:0]  int_id;
    logic        int_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    irq_scheduler #(.NSRC(6), .IDW(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .src_irq (src_irq),
        .int_req (int_req),
        .int_id  (int_id),
        .int_ack (int_ack)
    );

    always #10 clk = ~clk;

    // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = in service.
    logic [5:0] m_mask, m_pend, m_isr, m_prev;
    logic       m_armed, m_req;
    logic [2:0] m_id;
    int         m_phase;

    always @(posedge clk or posedge reset) begin : model
        logic [5:0] rise, nxt, elig;
        int win;
        bit found;
        if (reset) begin
            m_mask <= '0; m_pend <= '0; m_isr <= '0; m_prev <= '0;
            m_armed <= 1'b0; m_req <= 1'b0; m_id <= '0; m_phase <= 0;
        end else begin
            rise = m_armed ? (src_irq & ~m_prev) : 6'h00;
            nxt = m_pend;
            if (WE && Addr[3:2] == 2'd1) nxt = nxt & ~Din[5:0];
            elig = m_pend & m_mask;
            win = 0;
            found = 0;
            for (int i = 0; i < 6; i++) begin
                if (elig[i] && !found) begin
                    win = i;
                    found = 1;
                end
            end
            if (m_phase == 0 && found) begin
                m_id <= 3'(win);
                m_req <= 1'b1;
                m_phase <= 1;
            end else if (m_phase == 1 && int_ack) begin
                nxt[m_id] = 1'b0;
                m_isr <= 6'h01 << m_id;
                m_req <= 1'b0;
                m_phase <= 2;
            end else if (m_phase == 2 && WE && Addr[3:2] == 2'd3 && Din[2:0] == m_id) begin
                m_isr <= '0;
                m_phase <= 0;
            end
            m_pend <= nxt | rise;
            if (WE && Addr[3:2] == 2'd0) m_mask <= Din[5:0];
            m_prev <= src_irq;
            m_armed <= 1'b1;
        end
    end

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return {26'd0, m_mask};
            2'd1: return {26'd0, m_pend};
            2'd2: return {26'd0, m_isr};
            default: return {(m_phase == 2), 28'd0, m_id};
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check_output("model int_req", {31'd0, int_req}, {31'd0, m_req});
            if (m_req) check_output("model int_id", {29'd0, int_id}, {29'd0, m_id});
            check_output("model Dout", Dout, model_read(Addr[3:2]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din = d;
        WE = 1'b1;
        step();
        WE = 1'b0;
        Din = '0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] expected);
        Addr = {28'd0, a};
        #1;
        check_output(name, Dout, expected);
    endtask

    task automatic ack_step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check_output("reset int_req", {31'd0, int_req}, 32'd0);
        for (int a = 0; a < 4; a++) read_check("reset read", 2'(a), 32'd0);

        // Single pulse on source 2, full handshake.
        write_reg(2'd0, 32'h3F);
        src_irq = 6'h04;
        step();
        src_irq = 6'h00;
        read_check("t1 pending", 2'd1, 32'h04);
        check_output("t1 no req yet", {31'd0, int_req}, 32'd0);
        step();
        check_output("t1 req", {31'd0, int_req}, 32'd1);
        check_output("t1 id", {29'd0, int_id}, 32'd2);
        ack_step();
        read_check("t1 inservice", 2'd2, 32'h04);
        read_check("t1 pending cleared", 2'd1, 32'h00);
        read_check("t1 status", 2'd3, 32'h80000002);
        write_reg(2'd3, 32'd2);
        read_check("t1 status after eoi", 2'd3, 32'h00000002);

        // Sources 4 and 1 together: priority order.
        src_irq = 6'h12;
        step();
        src_irq = 6'h00;
        step();
        check_output("t2 first id", {29'd0, int_id}, 32'd1);
        ack_step();
        write_reg(2'd3, 32'd1);
        step();
        check_output("t2 second req", {31'd0, int_req}, 32'd1);
        check_output("t2 second id", {29'd0, int_id}, 32'd4);
        ack_step();
        write_reg(2'd3, 32'd4);

        // Masked source, then unmasked.
        write_reg(2'd0, 32'h01);
        src_irq = 6'h08;
        step();
        src_irq = 6'h00;
        read_check("t3 pending", 2'd1, 32'h08);
        step();
        check_output("t3 masked no req", {31'd0, int_req}, 32'd0);
        write_reg(2'd0, 32'h08);
        check_output("t3 req not yet", {31'd0, int_req}, 32'd0);
        step();
        check_output("t3 req", {31'd0, int_req}, 32'd1);
        check_output("t3 id", {29'd0, int_id}, 32'd3);
        ack_step();
        write_reg(2'd3, 32'd3);

        // Mismatched EOI ignored.
        write_reg(2'd0, 32'h3F);
        src_irq = 6'h04;
        step();
        src_irq = 6'h00;
        step();
        ack_step();
        write_reg(2'd3, 32'd5);
        read_check("t4 busy after bad eoi", 2'd3, 32'h80000002);
        read_check("t4 inservice held", 2'd2, 32'h04);
        write_reg(2'd3, 32'd2);
        read_check("t4 inservice cleared", 2'd2, 32'h00);
        read_check("t4 status idle", 2'd3, 32'h00000002);

        // W1C racing a capture edge on the same bit.
        write_reg(2'd0, 32'h00);
        src_irq = 6'h01;
        step();
        src_irq = 6'h00;
        step();
        src_irq = 6'h01;
        write_reg(2'd1, 32'h01);
        read_check("t5 set wins", 2'd1, 32'h01);
        write_reg(2'd1, 32'h01);
        read_check("t5 w1c clears", 2'd1, 32'h00);
        src_irq = 6'h00;

        // Reset in the middle of a request.
        write_reg(2'd0, 32'h3F);
        src_irq = 6'h02;
        step();
        src_irq = 6'h00;
        step();
        check_output("t6 req before reset", {31'd0, int_req}, 32'd1);
        src_irq = 6'h01;
        step();
        #1;
        reset = 1'b1;
        #1;
        check_output("t6 req dropped", {31'd0, int_req}, 32'd0);
        for (int a = 0; a < 4; a++) read_check("t6 reset read", 2'(a), 32'd0);
        #1;
        reset = 1'b0;
        repeat (3) step();
        check_output("t6 held src no req", {31'd0, int_req}, 32'd0);
        read_check("t6 held src no pending", 2'd1, 32'h00);
        write_reg(2'd0, 32'h3F);
        src_irq = 6'h00;
        step();
        src_irq = 6'h01;
        step();
        step();
        check_output("t6 re-edge req", {31'd0, int_req}, 32'd1);
        check_output("t6 re-edge id", {29'd0, int_id}, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
